// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 Pmod OLED pixel streamer.
//   - top-level FSM state encodings (RST_HOLD .. SEND_LO)
//   - SPI byte engine state encodings
//   - init command list (INIT_LEN bytes) and default panel geometry
package oled_pkg;

  localparam int DEF_WIDTH  = 96;
  localparam int DEF_HEIGHT = 64;
  localparam int INIT_LEN   = 19;

  // Top-level sequencer states
  typedef logic [2:0] oled_state_t;
  localparam oled_state_t RST_HOLD = 3'd0;
  localparam oled_state_t INIT     = 3'd1;
  localparam oled_state_t VCC_WAIT = 3'd2;
  localparam oled_state_t FETCH    = 3'd3;
  localparam oled_state_t SEND_HI  = 3'd4;
  localparam oled_state_t SEND_LO  = 3'd5;

  // SPI byte engine states
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_LEAD  = 2'd1;
  localparam tx_state_t TX_SHIFT = 2'd2;

  // Power-up command list: display off, 65k colour remap, start line / offset,
  // normal display, mux ratio 64, master config, column window 0..95,
  // row window 0..63, display on.
  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hA0;
      5'd2:    b = 8'h72;
      5'd3:    b = 8'hA1;
      5'd4:    b = 8'h00;
      5'd5:    b = 8'hA2;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'hA4;
      5'd8:    b = 8'hA8;
      5'd9:    b = 8'h3F;
      5'd10:   b = 8'hAD;
      5'd11:   b = 8'h8E;
      5'd12:   b = 8'h15;
      5'd13:   b = 8'h00;
      5'd14:   b = 8'h5F;
      5'd15:   b = 8'h75;
      5'd16:   b = 8'h00;
      5'd17:   b = 8'h3F;
      5'd18:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Write-only 4-wire SPI byte engine, mode 3, MSB first.
//   clock, reset : system clock, synchronous active-high reset
//   start        : accept data/dc (only while idle)
//   data, dc     : byte to send and its data/command flag
//   busy         : byte in flight (lead or shifting)
//   done         : one-cycle pulse on the last SCLK-high clock of the byte
//   cs/sclk/sdin/d_cn : panel pins
// Frame: 1 clock cs-low lead with sclk high, 8 x (CLK_DIV low + CLK_DIV high),
// then cs high for at least 1 clock -> 16*CLK_DIV+2 clocks per byte when
// the next start is issued in response to done.
module spi_byte_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       dc,
  output logic       busy,
  output logic       done,
  output logic       cs,
  output logic       sclk,
  output logic       sdin,
  output logic       d_cn
);

  localparam int              DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  tx_state_t     st;
  logic [DW-1:0] div;
  logic [2:0]    bitc;
  logic [7:0]    sh;

  assign busy = (st != TX_IDLE);
  // Raised one clock early so a registered start from the sequencer lands
  // in the single cs-high gap clock.
  assign done = (st == TX_SHIFT) && sclk && (bitc == 3'd0) && (div == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      st   <= TX_IDLE;
      div  <= '0;
      bitc <= '0;
      sh   <= '0;
      cs   <= 1'b1;
      sclk <= 1'b1;
      sdin <= 1'b0;
      d_cn <= 1'b0;
    end else begin
      case (st)
        TX_IDLE: begin
          if (start) begin
            cs   <= 1'b0;
            d_cn <= dc;
            sh   <= data;
            bitc <= 3'd7;
            st   <= TX_LEAD;
          end
        end
        TX_LEAD: begin
          // first falling edge carries the MSB
          sclk <= 1'b0;
          sdin <= sh[7];
          div  <= '0;
          st   <= TX_SHIFT;
        end
        TX_SHIFT: begin
          if (div != DIV_LAST) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bitc == 3'd0) begin
              cs <= 1'b1;
              st <= TX_IDLE;
            end else begin
              sclk <= 1'b0;
              sdin <= sh[6];
              sh   <= {sh[6:0], 1'b0};
              bitc <= bitc - 3'd1;
            end
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/oled_spi_streamer.sv
// SSD1331 Pmod OLED driver: power/reset sequencing, init command list, then
// continuous RGB565 frame streaming.
//   clock, reset    : system clock, synchronous active-high reset
//   pixel_data      : RGB565 for pixel_index, valid PIXEL_LATENCY clocks later
//   pixel_index     : row*WIDTH+col of the pixel being fetched
//   frame_begin     : pulse when pixel_index (re)starts at 0
//   sample_pixel    : pulse on the clock pixel_data is latched
//   sending_pixels  : high in the streaming phase
//   cs/sdin/sclk/d_cn, resn, vccen, pmoden : panel pins
module oled_spi_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int PIXEL_LATENCY = 2,
  parameter int RESET_CYCLES  = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sample_pixel,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sdin,
  output logic        sclk,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam int             NPIX     = WIDTH * HEIGHT;
  localparam int             CW       = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]  WAIT_END = CW'(RESET_CYCLES - 1);
  localparam logic [12:0]    IDX_LAST = 13'(NPIX - 1);

  oled_state_t             state;
  logic [CW-1:0]           wait_cnt;
  logic [4:0]              init_idx;
  logic [15:0]             pix_lat;
  // vld_pipe[0] marks the clock pixel_index took a new value; the bit reaching
  // vld_pipe[PIXEL_LATENCY] marks pixel_data valid for it.
  logic [PIXEL_LATENCY:0]  vld_pipe;
  logic                    tx_start;
  logic [7:0]              tx_byte;
  logic                    tx_dc;
  logic                    tx_busy;
  logic                    tx_done;
  logic                    sample_go;

  // Byte source follows the state, so a start issued together with a state
  // change already sees the right byte.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      INIT:    tx_byte = init_byte(init_idx);
      SEND_HI: tx_byte = pix_lat[15:8];
      SEND_LO: tx_byte = pix_lat[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  assign tx_dc          = (state == SEND_HI) || (state == SEND_LO);
  assign sending_pixels = (state == FETCH) || tx_dc;
  assign sample_go      = (state == FETCH) && vld_pipe[PIXEL_LATENCY] && !tx_busy;
  assign sample_pixel   = sample_go;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RST_HOLD;
      wait_cnt    <= '0;
      init_idx    <= '0;
      pix_lat     <= '0;
      vld_pipe    <= '0;
      tx_start    <= 1'b0;
      resn        <= 1'b0;
      vccen       <= 1'b0;
      pmoden      <= 1'b0;
      pixel_index <= '0;
      frame_begin <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      frame_begin <= 1'b0;
      vld_pipe    <= {vld_pipe[PIXEL_LATENCY-1:0], 1'b0};
      case (state)
        RST_HOLD: begin
          pmoden <= 1'b1;
          // hold time counts from the first clock pmoden is seen high
          if (pmoden) begin
            if (wait_cnt == WAIT_END) begin
              wait_cnt <= '0;
              resn     <= 1'b1;
              init_idx <= '0;
              tx_start <= 1'b1;
              state    <= INIT;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        INIT: begin
          if (tx_done) begin
            if (init_idx == 5'(INIT_LEN - 1)) begin
              vccen <= 1'b1;
              state <= VCC_WAIT;
            end else begin
              init_idx <= init_idx + 5'd1;
              tx_start <= 1'b1;
            end
          end
        end
        VCC_WAIT: begin
          if (wait_cnt == WAIT_END) begin
            wait_cnt    <= '0;
            pixel_index <= '0;
            frame_begin <= 1'b1;
            vld_pipe[0] <= 1'b1;
            state       <= FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FETCH: begin
          if (sample_go) begin
            pix_lat  <= pixel_data;
            tx_start <= 1'b1;
            state    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (tx_done) begin
            tx_start <= 1'b1;
            state    <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_done) begin
            vld_pipe[0] <= 1'b1;
            state       <= FETCH;
            // panel auto-wraps inside the init window; only the index restarts
            if (pixel_index == IDX_LAST) begin
              pixel_index <= '0;
              frame_begin <= 1'b1;
            end else begin
              pixel_index <= pixel_index + 13'd1;
            end
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clock (clock),
    .reset (reset),
    .start (tx_start),
    .data  (tx_byte),
    .dc    (tx_dc),
    .busy  (tx_busy),
    .done  (tx_done),
    .cs    (cs),
    .sclk  (sclk),
    .sdin  (sdin),
    .d_cn  (d_cn)
  );

endmodule
